uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001: Parameter N_REQ, default 4; number of byte requesters, legal range 1..8.
REQ-002: Parameter CLKS_PER_BIT, default 104; clock cycles per UART bit (12 MHz / 115200), legal minimum 2.
REQ-003: CLK_12MHZ  input  1  sole clock; all state is updated on its rising edge.
REQ-004: RST_N  input  1  asynchronous, active-low reset.
REQ-005: REQ_VALID  input  N_REQ  per-requester byte-available flag.
REQ-006: REQ_DATA  input  8*N_REQ  packed bytes; requester i occupies bits [8i+7:8i].
REQ-007: REQ_READY  output  N_REQ  one-hot acceptance strobe; at most one bit is high in any cycle.
REQ-008: GRANT_ID  output  clog2(N_REQ), minimum 1  index of the requester whose byte is on the line.
REQ-009: BUSY  output  1  high while a frame is in progress.
REQ-010: UART_TX  output  1  serial line, 8N1 framing, idle high.

Function
REQ-011: FSM states are IDLE, START, DATA and STOP; all other encodings return to IDLE.
REQ-012: IDLE: if any REQ_VALID bit is high, the first set bit at or after rr_ptr (wrapping modulo N_REQ) wins the arbitration.
REQ-013: The winner's REQ_READY bit is asserted combinationally in that same IDLE cycle; the byte is latched, GRANT_ID is loaded, and the FSM enters START on the next edge.
REQ-014: At each grant, rr_ptr is set to (winner+1) mod N_REQ.
REQ-015: START: UART_TX is 0 for CLKS_PER_BIT cycles, then the FSM enters DATA.
REQ-016: DATA: 8 bits are sent LSB first, each held for CLKS_PER_BIT cycles; the bit index counts 0..7, then the FSM enters STOP.
REQ-017: STOP: UART_TX is 1 for CLKS_PER_BIT cycles, then the FSM enters IDLE.
REQ-018: Frame length is exactly 10*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
REQ-019: There is at least one IDLE cycle between frames, so back-to-back frames are 10*CLKS_PER_BIT+1 cycles apart.
REQ-020: BUSY is high in START, DATA and STOP and low in IDLE.
REQ-021: UART_TX is registered, with no combinational path from any input.
REQ-022: REQ_READY is low in every state except IDLE.
REQ-023: REQ_VALID and REQ_DATA changes outside IDLE are ignored.
REQ-024: A requester drops REQ_VALID only after seeing REQ_READY; if VALID is withdrawn before a grant, no byte is sent and no error is raised.
REQ-025: Changes to the latched byte during a frame have no effect on the transmitted bits.
REQ-026: The bit-period counter width is clog2(CLKS_PER_BIT).
REQ-027: The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary.
REQ-028: With N_REQ=1, rr_ptr and GRANT_ID stay at 0 and behaviour reduces to a single-source transmitter.

Reset
REQ-029: While RST_N is low, the block enters IDLE asynchronously and holds: UART_TX=1, BUSY=0, REQ_READY=0, GRANT_ID=0, rr_ptr=0, counters=0, latched byte=0.
REQ-030: A reset asserted mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
REQ-031: After a mid-frame reset, the aborted byte is not retransmitted.
REQ-032: Arbitration begins on the first rising edge after RST_N deasserts.

Structure
REQ-033: A shared package uart_arb_pkg holds the state encoding (IDLE=0, START=1, DATA=2, STOP=3), the 8-bit data width constant and the default CLKS_PER_BIT constant.
REQ-034: The 8N1 serializer (START/DATA/STOP FSM, bit counter, shift register) is the sub-module uart_tx_serializer, with ports CLK_12MHZ, RST_N, start, data[7:0], busy and tx.
REQ-035: The arbiter logic (rr_ptr, winner select, REQ_READY, GRANT_ID) lives in uart_tx_arbiter.

Verification (CLKS_PER_BIT=4, N_REQ=4 unless stated)
REQ-036: Single byte: REQ_VALID=4'b0001, byte 0x55 -> REQ_READY[0] high for 1 cycle; UART_TX = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; BUSY high for 40 cycles; GRANT_ID=0.
REQ-037: All-contend: REQ_VALID=4'hF held with bytes 0xA0..0xA3, refilled after each READY -> grant order 0,1,2,3,0; frames start 41 cycles apart.
REQ-038: Pointer wrap: grant to requester 3, then REQ_VALID=4'b1001 -> next grant goes to 0, not 3.
REQ-039: Late request: REQ_VALID[2] rises during the DATA state of another frame -> no REQ_READY until the next IDLE cycle; REQ_DATA changes mid-frame leave the transmitted bits unaltered.
REQ-040: Mid-frame reset: RST_N pulled low at bit 3 of byte 0xFF -> UART_TX=1 and BUSY=0 without waiting for a clock edge; after release, no frame is sent until REQ_VALID is asserted.
REQ-041: Default parameters: byte 0x00 at CLKS_PER_BIT=104 -> low period exactly 936 cycles (start + 8 data bits), stop bit 104 cycles.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter and its 8N1 serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_arb_pkg;

  // Serializer frame states; the encoding is fixed so waveforms read the same everywhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 104;  // 12 MHz / 115200 baud

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit.
// Latency: line goes low on the edge after start; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: start is honoured only while busy is low; it is ignored mid-frame.
//
// Ports:
//   CLK_12MHZ  clock
//   RST_N      asynchronous active-low reset
//   start      load data and begin a frame (sampled only in IDLE)
//   data       byte to transmit
//   busy       high from the first start-bit cycle until the frame ends
//   tx         registered serial output, idle high
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              CLK_12MHZ,
  input  logic              RST_N,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              tx
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t         state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // tx and busy are loaded one edge ahead of the state they describe so that
  // both are plain flops with no decode after them.
  always_ff @(posedge CLK_12MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          busy    <= 1'b0;
          if (start) begin
            shreg <= data;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[DATA_W-1:1]};
              // Next bit is the one about to become shreg[0].
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N_REQ byte requesters into one 8N1 UART transmitter.
// Latency: REQ_READY is combinational in the idle cycle; the start bit begins on the next edge.
// Backpressure: REQ_READY stays low for the whole frame; requesters hold VALID/DATA until READY.
//
// Ports:
//   CLK_12MHZ  clock
//   RST_N      asynchronous active-low reset
//   REQ_VALID  per-requester byte-available flags
//   REQ_DATA   packed bytes, requester i in bits [8i+7:8i]
//   REQ_READY  one-hot acceptance strobe, only ever high in an idle cycle
//   GRANT_ID   index of the requester whose byte is on the line
//   BUSY       high while a frame is in progress
//   UART_TX    serial line, idle high
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  localparam int GW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    CLK_12MHZ,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        REQ_VALID,
  input  logic [DATA_W*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]        REQ_READY,
  output logic [GW-1:0]           GRANT_ID,
  output logic                    BUSY,
  output logic                    UART_TX
);

  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     win_idx;
  logic              win_found;
  logic              grant;
  logic [DATA_W-1:0] win_data;

  // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  // BUSY mirrors the serializer state, so !BUSY is exactly the idle cycle.
  // RST_N gates the strobe so nothing is accepted while reset is held.
  assign grant    = RST_N && !BUSY && win_found;
  assign win_data = REQ_DATA[DATA_W*int'(win_idx) +: DATA_W];

  always_comb begin
    REQ_READY = '0;
    for (int i = 0; i < N_REQ; i++) begin
      REQ_READY[i] = grant && (int'(win_idx) == i);
    end
  end

  always_ff @(posedge CLK_12MHZ or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr   <= '0;
      GRANT_ID <= '0;
    end else if (grant) begin
      GRANT_ID <= win_idx;
      if (int'(win_idx) == N_REQ - 1) rr_ptr <= '0;
      else                            rr_ptr <= win_idx + 1'b1;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .CLK_12MHZ (CLK_12MHZ),
    .RST_N     (RST_N),
    .start     (grant),
    .data      (win_data),
    .busy      (BUSY),
    .tx        (UART_TX)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a CLKS_PER_BIT=4 instance driven through directed and
// random frames, plus a default-parameter instance for the long bit period.
// Expected line levels come from the 8N1 frame definition, winners from round-robin order.
module tb_uart_tx_arbiter;

  localparam int C = 4;
  localparam int FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        uart_tx;

  logic [3:0]  d_valid;
  logic [31:0] d_data;
  logic [3:0]  d_ready;
  logic [1:0]  d_gid;
  logic        d_busy;
  logic        d_tx;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_grant;
  int m_ptr;
  logic [3:0]  cur_valid;
  logic [31:0] cur_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(.N_REQ(4), .CLKS_PER_BIT(C)) dut (
    .CLK_12MHZ (clk),
    .RST_N     (rst_n),
    .REQ_VALID (req_valid),
    .REQ_DATA  (req_data),
    .REQ_READY (req_ready),
    .GRANT_ID  (grant_id),
    .BUSY      (busy),
    .UART_TX   (uart_tx)
  );

  uart_tx_arbiter dut_d (
    .CLK_12MHZ (clk),
    .RST_N     (rst_n),
    .REQ_VALID (d_valid),
    .REQ_DATA  (d_data),
    .REQ_READY (d_ready),
    .GRANT_ID  (d_gid),
    .BUSY      (d_busy),
    .UART_TX   (d_tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int model_win(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Line level c cycles after the frame starts: start bit, 8 data bits LSB first, stop bit.
  function automatic logic model_tx(input logic [7:0] b, input int c);
    int k;
    k = c / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Checks one full frame; the requester inputs are replaced partway through DATA.
  task automatic do_frame(input int w, input logic [7:0] b, input logic [3:0] uv, input logic [31:0] ud);
    for (int c = 0; c < FRAME; c++) begin
      tick;
      if (c == 3 * C) begin
        req_valid = uv;
        req_data  = ud;
        cur_valid = uv;
        cur_data  = ud;
        #1;
      end
      chk("tx_bit", {31'd0, uart_tx}, {31'd0, model_tx(b, c)});
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      chk("ready_in_frame", {28'd0, req_ready}, 32'd0);
      chk("grant_id", {30'd0, grant_id}, w);
    end
    tick;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("tx_idle", {31'd0, uart_tx}, 32'd1);
  endtask

  task automatic expect_frame(input logic [3:0] uv, input logic [31:0] ud, input bit spacing);
    int w;
    int n;
    logic [7:0] b;
    logic [3:0] oh;
    w = model_win(cur_valid, m_ptr);
    if (w < 0) w = 0;
    b = cur_data[8*w +: 8];
    oh = '0;
    oh[w] = 1'b1;
    n = 0;
    #1;
    while (req_ready === 4'b0 && n < 30) begin
      tick;
      #1;
      n++;
    end
    chk("ready_onehot", {28'd0, req_ready}, {28'd0, oh});
    if (spacing) chk("frame_spacing", cyc - last_grant, FRAME + 1);
    last_grant = cyc;
    m_ptr = (w + 1) % 4;
    do_frame(w, b, uv, ud);
  endtask

  initial begin
    int n;
    int lo;
    int hi;
    logic [3:0]  rv;
    logic [31:0] rd;

    rst_n = 1'b0;
    req_valid = '0;
    req_data  = '0;
    d_valid   = '0;
    d_data    = '0;
    cur_valid = '0;
    cur_data  = '0;
    m_ptr = 0;
    last_grant = 0;
    tick;
    tick;
    #1;
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_tx_default", {31'd0, d_tx}, 32'd1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_no_req", {31'd0, busy}, 32'd0);

    // All requesters contend with bytes 0xA0..0xA3; pointer wrap follows grant 3.
    req_valid = 4'hF;
    req_data  = 32'hA3A2_A1A0;
    cur_valid = req_valid;
    cur_data  = req_data;
    expect_frame(4'hF, 32'hA3A2_A1A0, 1'b0);
    expect_frame(4'hF, 32'hA3A2_A1A0, 1'b1);
    expect_frame(4'hF, 32'hA3A2_A1A0, 1'b1);
    expect_frame(4'b1001, 32'hA3A2_A1A0, 1'b1);
    // Grant 0 after 3; then a lone 0x55 from requester 0.
    expect_frame(4'b0001, 32'h0000_0055, 1'b1);
    // Requester 2 asserts late, mid-DATA, while byte 0 is overwritten.
    expect_frame(4'b0100, 32'h00C3_00AA, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rv = 4'($urandom_range(1, 15));
      rd = $urandom;
      expect_frame(rv, rd, 1'b1);
    end
    expect_frame(4'b0010, 32'h0000_FF00, 1'b1);

    // 0xFF from requester 1, reset pulled at data bit 3.
    n = 0;
    #1;
    while (req_ready === 4'b0 && n < 30) begin
      tick;
      #1;
      n++;
    end
    chk("ready_ff", {28'd0, req_ready}, 32'h2);
    for (int c = 0; c < 4 * C + 2; c++) tick;
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    req_valid = '0;
    cur_valid = '0;
    #1;
    chk("abort_tx", {31'd0, uart_tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {28'd0, req_ready}, 32'd0);
    chk("abort_gid", {30'd0, grant_id}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      chk("post_reset_quiet_busy", {31'd0, busy}, 32'd0);
      chk("post_reset_quiet_tx", {31'd0, uart_tx}, 32'd1);
    end
    // Pointer restarts at 0, so requester 0 beats requester 3.
    req_valid = 4'b1001;
    req_data  = 32'h5A00_003C;
    cur_valid = req_valid;
    cur_data  = req_data;
    expect_frame(4'b0000, 32'h0, 1'b0);

    // Default parameters: byte 0x00 at 104 clocks per bit.
    d_valid = 4'b0001;
    d_data  = 32'h0;
    n = 0;
    #1;
    while (d_ready === 4'b0 && n < 10) begin
      tick;
      #1;
      n++;
    end
    chk("default_ready", {28'd0, d_ready}, 32'h1);
    tick;
    d_valid = '0;
    lo = 0;
    while (d_tx === 1'b0 && lo < 2000) begin
      lo++;
      tick;
    end
    chk("default_low_period", lo, 32'd936);
    hi = 0;
    while (d_busy === 1'b1 && hi < 2000) begin
      hi++;
      tick;
    end
    chk("default_stop_bit", hi, 32'd104);
    chk("default_tx_idle", {31'd0, d_tx}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
